// File: rtl/reg_wr_arb_if.sv
// Register-write bus bundle carrying LANES requesters side by side (lane i occupies slice i).
// The master drives address/data/strobe/enable; the slave answers with wait and ack.
interface reg_wr_arb_if #(
    parameter int LANES      = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [LANES*ADDR_WIDTH-1:0] wr_addr;
    logic [LANES*DATA_WIDTH-1:0] wr_data;
    logic [LANES*STRB_WIDTH-1:0] wr_strb;
    logic [LANES-1:0]            wr_en;
    logic [LANES-1:0]            wr_wait;
    logic [LANES-1:0]            wr_ack;

    modport master (
        output wr_addr, wr_data, wr_strb, wr_en,
        input  wr_wait, wr_ack
    );

    modport slave (
        input  wr_addr, wr_data, wr_strb, wr_en,
        output wr_wait, wr_ack
    );
endinterface

// File: rtl/reg_wr_arb.sv
// Round-robin arbiter sharing one register-write port among PORTS requesters.
// Optional downstream ack timeout is enabled by defining REG_WR_ARB_TIMEOUT_EN.
module reg_wr_arb #(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic         clk,
    input  logic         rst,
    reg_wr_arb_if.slave  s_reg,
    reg_wr_arb_if.master m_reg,
    output logic         timeout_err
);
    localparam int GW = $clog2(PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_q;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  en_q;

`ifdef REG_WR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]         cnt_q;
    logic                  terr_q;
`endif

    logic [ADDR_WIDTH-1:0] req_addr [PORTS];
    logic [DATA_WIDTH-1:0] req_data [PORTS];
    logic [STRB_WIDTH-1:0] req_strb [PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            assign req_addr[gi] = s_reg.wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_data[gi] = s_reg.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_strb[gi] = s_reg.wr_strb[gi*STRB_WIDTH +: STRB_WIDTH];

            // Queued requesters always stall; only the owner in BUSY sees the bank's wait.
            assign s_reg.wr_wait[gi] = s_reg.wr_en[gi] &&
                                       ((grant_q != GW'(gi)) || (state_q != ST_BUSY) || m_reg.wr_wait[0]);
            assign s_reg.wr_ack[gi]  = (state_q == ST_ACK) && (grant_q == GW'(gi)) && s_reg.wr_en[gi];
        end
    endgenerate

    // Search upward from the requester after the last one served, wrapping at PORTS.
    logic [GW:0]   rr_idx;
    logic [GW-1:0] pick_d;
    logic          pick_found;

    always_comb begin
        pick_d     = '0;
        pick_found = 1'b0;
        rr_idx     = '0;
        for (int off = 1; off <= PORTS; off++) begin
            rr_idx = {1'b0, last_grant_q} + (GW+1)'(off);
            if (rr_idx >= (GW+1)'(PORTS)) begin
                rr_idx = rr_idx - (GW+1)'(PORTS);
            end
            if (!pick_found && s_reg.wr_en[rr_idx[GW-1:0]]) begin
                pick_d     = rr_idx[GW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(PORTS - 1);
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            en_q         <= 1'b0;
`ifdef REG_WR_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            terr_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|s_reg.wr_en) begin
                        grant_q <= pick_d;
                        addr_q  <= req_addr[pick_d];
                        data_q  <= req_data[pick_d];
                        strb_q  <= req_strb[pick_d];
                        en_q    <= 1'b1;
`ifdef REG_WR_ARB_TIMEOUT_EN
                        cnt_q   <= CW'(TIMEOUT - 1);
`endif
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_reg.wr_ack[0]) begin
                        en_q    <= 1'b0;
                        state_q <= ST_ACK;
                    end
`ifdef REG_WR_ARB_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        terr_q  <= 1'b1;
                        state_q <= ST_ACK;
                    end else if (!m_reg.wr_wait[0]) begin
                        cnt_q   <= cnt_q - CW'(1);
                    end
`endif
                end
                ST_ACK: begin
                    last_grant_q <= grant_q;
`ifdef REG_WR_ARB_TIMEOUT_EN
                    terr_q       <= 1'b0;
`endif
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_reg.wr_addr = addr_q;
    assign m_reg.wr_data = data_q;
    assign m_reg.wr_strb = strb_q;
    assign m_reg.wr_en   = en_q;

`ifdef REG_WR_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wr_arb.sv
// Self-checking bench for reg_wr_arb: directed scenarios then randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_reg_wr_arb;
    localparam int PORTS   = 3;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 4;
`ifdef REG_WR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic timeout_err;

    always #5 clk = ~clk;

    reg_wr_arb_if #(.LANES(PORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) s_if ();
    reg_wr_arb_if #(.LANES(1),     .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) m_if ();

    reg_wr_arb #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_reg       (s_if),
        .m_reg       (m_if),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the transaction currently owning the shared port.
    int            owner;       // -1 when the shared port is free
    bit            closing;     // completion cycle of the owner's transaction
    bit            closing_to;  // completion was caused by the timeout
    int            last;        // requester served most recently
    int            budget;      // non-wait cycles left before timeout
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic [SW-1:0] lat_strb;

    logic [PORTS-1:0] exp_ack, exp_wait, seen_ack;
    bit               exp_men, exp_terr;
    int               gap [PORTS];

    task automatic model_reset();
        owner = -1; closing = 0; closing_to = 0; last = PORTS - 1; budget = 0;
        lat_addr = '0; lat_data = '0; lat_strb = '0;
    endtask

    task automatic put_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
        s_if.wr_addr[i*AW +: AW] = a;
        s_if.wr_data[i*DW +: DW] = d;
        s_if.wr_strb[i*SW +: SW] = s;
    endtask

    task automatic sample();
        @(negedge clk);
        exp_men  = (owner >= 0) && !closing;
        exp_terr = closing && closing_to;
        for (int i = 0; i < PORTS; i++) begin
            exp_ack[i]  = closing && (owner == i) && s_if.wr_en[i];
            exp_wait[i] = s_if.wr_en[i] && !((owner == i) && !closing && !m_if.wr_wait[0]);
        end
        check("m_en", m_if.wr_en, exp_men);
        if (exp_men) begin
            check("m_addr", m_if.wr_addr, lat_addr);
            check("m_data", m_if.wr_data, lat_data);
            check("m_strb", m_if.wr_strb, lat_strb);
        end
        check("s_wait", s_if.wr_wait, exp_wait);
        check("s_ack", s_if.wr_ack, exp_ack);
        check("timeout_err", timeout_err, exp_terr);
    endtask

    task automatic advance();
        @(posedge clk);
        seen_ack = exp_ack;
        if (rst) begin
            model_reset();
        end else if (closing) begin
            $display("txn: req=%0d addr=%08h data=%08h strb=%h acked=%0d timeout=%0d",
                     owner, lat_addr, lat_data, lat_strb, |exp_ack, closing_to);
            last = owner; owner = -1; closing = 0;
        end else if (owner >= 0) begin
            if (m_if.wr_ack[0]) begin
                closing = 1; closing_to = 0;
            end else if (TO_EN && budget == 0) begin
                closing = 1; closing_to = 1;
            end else if (!m_if.wr_wait[0]) begin
                budget--;
            end
        end else if (|s_if.wr_en) begin
            for (int k = 1; k <= PORTS && owner < 0; k++) begin
                int c;
                c = (last + k) % PORTS;
                if (s_if.wr_en[c]) owner = c;
            end
            lat_addr = s_if.wr_addr[owner*AW +: AW];
            lat_data = s_if.wr_data[owner*DW +: DW];
            lat_strb = s_if.wr_strb[owner*SW +: SW];
            budget   = TIMEOUT - 1;
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    int order[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_if.wr_addr = '0; s_if.wr_data = '0; s_if.wr_strb = '0; s_if.wr_en = '0;
        m_if.wr_wait = '0; m_if.wr_ack = '0;
        seen_ack = '0; exp_ack = '0;
        for (int i = 0; i < PORTS; i++) gap[i] = 0;
        @(posedge clk); #1;
        model_reset();
        sample();
        check("rst_m_en", m_if.wr_en, 1'b0);
        check("rst_m_addr", m_if.wr_addr, 32'h0);
        check("rst_m_data", m_if.wr_data, 32'h0);
        check("rst_m_strb", m_if.wr_strb, 4'h0);
        check("rst_s_ack", s_if.wr_ack, 3'b000);
        check("rst_terr", timeout_err, 1'b0);
        advance();
        rst = 1'b0;

        // Single write
        put_req(0, 32'h10, 32'hDEADBEEF, 4'hF);
        s_if.wr_en = 3'b001;
        tick();
        m_if.wr_ack = 1'b1;
        sample();
        check("sw_m_en", m_if.wr_en, 1'b1);
        check("sw_m_addr", m_if.wr_addr, 32'h10);
        check("sw_m_data", m_if.wr_data, 32'hDEADBEEF);
        check("sw_m_strb", m_if.wr_strb, 4'hF);
        check("sw_wait0", s_if.wr_wait[0], 1'b0);
        advance();
        m_if.wr_ack = 1'b0;
        sample();
        check("sw_ack", s_if.wr_ack, 3'b001);
        check("sw_m_en_off", m_if.wr_en, 1'b0);
        advance();
        s_if.wr_en = 3'b000;
        tick();

        // Contention between requesters 0 and 1 from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put_req(0, 32'h100, 32'h0000_0A0A, 4'h3);
        put_req(1, 32'h104, 32'h0000_0B0B, 4'hC);
        m_if.wr_ack = 1'b1;
        seen_ack = '0;
        for (int c = 0; c < 14; c++) begin
            s_if.wr_en = {1'b0, !seen_ack[1], !seen_ack[0]};
            sample();
            if (owner == 0 && !closing) check("ct_wait1", s_if.wr_wait[1], 1'b1);
            for (int i = 0; i < PORTS; i++) if (s_if.wr_ack[i]) order.push_back(i);
            advance();
        end
        m_if.wr_ack = 1'b0;
        s_if.wr_en = 3'b000;
        tick();
        tick();
        if (order.size() < 4) check("ct_grants", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++) check("ct_order", order[k], k % 2);

        // Bank stall for 10 cycles
        put_req(2, 32'h200, 32'h1234_5678, 4'h5);
        s_if.wr_en = 3'b100;
        tick();
        m_if.wr_wait = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            check("st_wait2", s_if.wr_wait[2], 1'b1);
            check("st_m_en", m_if.wr_en, 1'b1);
            advance();
        end
        m_if.wr_wait = 1'b0;
        m_if.wr_ack = 1'b1;
        sample();
        check("st_wait2_rel", s_if.wr_wait[2], 1'b0);
        advance();
        m_if.wr_ack = 1'b0;
        sample();
        check("st_ack", s_if.wr_ack, 3'b100);
        check("st_terr", timeout_err, 1'b0);
        advance();
        s_if.wr_en = 3'b000;
        tick();

        // Bank never answers
        put_req(1, 32'h300, 32'hCAFE_F00D, 4'hF);
        s_if.wr_en = 3'b010;
        tick();
`ifdef REG_WR_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            sample();
            check("to_m_en", m_if.wr_en, 1'b1);
            advance();
        end
        sample();
        check("to_ack", s_if.wr_ack, 3'b010);
        check("to_terr", timeout_err, 1'b1);
        check("to_m_en_off", m_if.wr_en, 1'b0);
        advance();
`else
        for (int c = 0; c < 20; c++) begin
            sample();
            check("to_m_en_hold", m_if.wr_en, 1'b1);
            advance();
        end
        m_if.wr_ack = 1'b1;
        tick();
        m_if.wr_ack = 1'b0;
        sample();
        check("to_ack", s_if.wr_ack, 3'b010);
        check("to_terr", timeout_err, 1'b0);
        advance();
`endif
        s_if.wr_en = 3'b000;
        tick();

        // Abandon mid-BUSY
        put_req(0, 32'h400, 32'h0BAD_0BAD, 4'h1);
        s_if.wr_en = 3'b001;
        tick();
        tick();
        s_if.wr_en = 3'b000;
        sample();
        check("ab_m_en", m_if.wr_en, 1'b1);
        advance();
        m_if.wr_ack = 1'b1;
        tick();
        m_if.wr_ack = 1'b0;
        sample();
        check("ab_no_ack", s_if.wr_ack, 3'b000);
        advance();
        sample();
        check("ab_idle_m_en", m_if.wr_en, 1'b0);
        advance();

        // Reset during BUSY
        put_req(1, 32'h500, 32'h1111_1111, 4'h2);
        put_req(2, 32'h504, 32'h2222_2222, 4'h4);
        s_if.wr_en = 3'b110;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put_req(0, 32'hA0, 32'h3333_3333, 4'h8);
        s_if.wr_en = 3'b111;
        sample();
        check("rb_m_en", m_if.wr_en, 1'b0);
        check("rb_no_ack", s_if.wr_ack, 3'b000);
        advance();
        sample();
        check("rb_first_addr", m_if.wr_addr, 32'hA0);
        check("rb_wait0", s_if.wr_wait[0], 1'b0);
        advance();
        m_if.wr_ack = 1'b1;
        tick();
        m_if.wr_ack = 1'b0;
        tick();
        s_if.wr_en = 3'b000;
        tick();

        // Randomized traffic
        seen_ack = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < PORTS; i++) begin
                if (seen_ack[i]) begin
                    s_if.wr_en[i] = 1'b0;
                    gap[i] = $urandom_range(0, 2);
                end else if (s_if.wr_en[i]) begin
                    if ($urandom_range(0, 59) == 0) s_if.wr_en[i] = 1'b0;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    put_req(i, $urandom, $urandom, SW'($urandom));
                    s_if.wr_en[i] = 1'b1;
                end
            end
            m_if.wr_wait = ($urandom_range(0, 3) == 0);
            m_if.wr_ack  = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_wr_arb.md
# reg_wr_arb

Round-robin arbiter that shares one register-write port among `PORTS` register-write requesters, such as AXI-Lite register interface write bridges and internal config sequencers. Each requester holds its enable until it receives an acknowledge. The arbiter grants one requester at a time and forwards a registered copy of that requester's address, data and strobe to the shared register bank. It routes the bank's acknowledge back to the granted requester and holds every other requester in wait. It sits between the AXI-Lite write bridges and the UDP-core control register file.

## Interface
Parameters:
- `PORTS`, 2, number of requesters (≥2)
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 32, register address width
- `STRB_WIDTH`, `DATA_WIDTH/8`, byte-strobe width
- `TIMEOUT`, 4, downstream ack timeout in non-wait cycles (≥2)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_reg_wr_addr`  in  `PORTS*ADDR_WIDTH`  requester addresses; requester i occupies slice i
- `s_reg_wr_data`  in  `PORTS*DATA_WIDTH`  requester write data
- `s_reg_wr_strb`  in  `PORTS*STRB_WIDTH`  requester byte strobes
- `s_reg_wr_en`  in  `PORTS`  request, held by the requester until its ack
- `s_reg_wr_wait`  out  `PORTS`  requester stall indication
- `s_reg_wr_ack`  out  `PORTS`  one-cycle completion pulse per requester
- `m_reg_wr_addr`  out  `ADDR_WIDTH`  shared-port address
- `m_reg_wr_data`  out  `DATA_WIDTH`  shared-port data
- `m_reg_wr_strb`  out  `STRB_WIDTH`  shared-port strobes
- `m_reg_wr_en`  out  1  shared-port write enable
- `m_reg_wr_wait`  in  1  bank stall
- `m_reg_wr_ack`  in  1  bank completion
- `timeout_err`  out  1  one-cycle pulse when a transaction ends by timeout

## Operation
The arbiter is a three-state FSM: IDLE, BUSY, ACK.
- **IDLE**
  - If any `s_reg_wr_en` bit is set, select a requester by round-robin, searching from `last_grant+1` upward with wrap-around.
  - Latch the selected index into `grant` and capture that requester's addr, data and strb into the `m_*` registers.
  - Load the timeout counter with `TIMEOUT-1` and go to BUSY.
- **BUSY**
  - `m_reg_wr_en`=1 with the captured values held constant.
  - On `m_reg_wr_ack`=1, go to ACK.
- **ACK**
  - `m_reg_wr_en`=0.
  - `s_reg_wr_ack[grant]`=1, unless `s_reg_wr_en[grant]` is 0 this cycle; an abandoned request gets no ack.
  - `last_grant`←`grant`, then go to IDLE.
- **Wait routing**
  - `s_reg_wr_wait[i]` = `s_reg_wr_en[i]` && (i≠`grant` || state≠BUSY || `m_reg_wr_wait`).
  - Net effect: a queued requester always sees wait, and the granted requester sees the bank's wait.
- **Abandoned request:** if the granted requester drops its en during BUSY, the downstream transaction still runs to ack or timeout.
- **Fairness:** at most `PORTS-1` other transactions are serviced before any asserted requester is granted.
- **Reset values:**
  - State=IDLE, `last_grant`=`PORTS-1` (so requester 0 has first priority).
  - `m_reg_wr_en`=0, `m_reg_wr_addr/data/strb`=0.
  - `s_reg_wr_ack`=0, `timeout_err`=0.
- **Reset mid-transaction:** `rst` in any state returns to IDLE next cycle. No ack is issued and `m_reg_wr_en` drops immediately.

## Timing
- Request first seen at cycle 0 in IDLE → `m_reg_wr_en`=1 at cycle 1.
- `m_reg_wr_ack` at cycle k → `s_reg_wr_ack` pulse and `m_reg_wr_en`=0 at cycle k+1 → IDLE at cycle k+2.
- Best case is one write per 3 cycles; back-to-back grants are separated by the ACK cycle plus the IDLE cycle.
- The ACK state guarantees a requester that drops en on ack is never re-granted for a stale request.
- `m_reg_wr_ack` is sampled only in BUSY; an ack arriving in IDLE or ACK is ignored.
- Timeout counter, macro enabled:
  - In BUSY, decrements on every cycle with `m_reg_wr_wait`=0 and the counter ≠0.
  - In BUSY with counter=0 and no ack: go to ACK, deliver the normal requester ack, and pulse `timeout_err` in the ACK cycle.
  - Ack and expiry in the same cycle count as a normal ack; `timeout_err` stays 0.

## Configuration
- Macro: `REG_WR_ARB_TIMEOUT_EN`.
- Defined: timeout counter (`$clog2(TIMEOUT)` bits) and `timeout_err` are implemented as described above.
- Undefined: no counter; BUSY waits indefinitely for `m_reg_wr_ack`; `timeout_err` is tied to 0.

## Test plan
- **Single write:** reset, then requester 0 requests addr 0x10, data 0xDEADBEEF, strb 0xF; bank acks on the first BUSY cycle.
  - Required: `m_reg_wr_en` high at cycle 1 with those values.
  - Required: `s_reg_wr_ack[0]` pulses at cycle 2; `s_reg_wr_wait[0]`=0 while granted and the bank is not waiting.
- **Contention:** requesters 0 and 1 hold en continuously, each dropping en after its ack and reasserting 1 cycle later.
  - Required: grants alternate 0,1,0,1; `s_reg_wr_wait[1]`=1 throughout requester 0's BUSY.
- **Bank stall:** bank holds `m_reg_wr_wait`=1 for 10 cycles, then acks.
  - Required: no timeout; the granted requester sees wait=1 for those cycles; ack delivered after them.
- **Timeout (macro on, `TIMEOUT`=4):** bank never acks or waits.
  - Required: ACK state entered after 4 BUSY cycles; `s_reg_wr_ack` and `timeout_err` pulse together.
  - Macro off: `m_reg_wr_en` stays high indefinitely.
- **Abandon:** granted requester drops en mid-BUSY, then the bank acks.
  - Required: no `s_reg_wr_ack` pulse; FSM returns to IDLE.
- **Reset in BUSY:** assert `rst` for 1 cycle during BUSY.
  - Required: `m_reg_wr_en`=0 next cycle, no ack, and requester 0 is granted first afterwards.
